// File: rtl/audio_tone_gen_if.sv
// Bundle of the control inputs and sample/interrupt outputs for audio_tone_gen.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-clk strobes.
// Signals:
//   ce                 6 MHz clock enable
//   sq1_freq, sq2_freq 12-bit channel periods in ticks
//   audio_ctl          [3:0] mode, [6:4] int B prescaler, [7] unused
//   volume             [6:0] amplitude, [7] DC bit for modes 0/8
//   ctl_wr             one-clk strobe, audio_ctl was just written
//   audio_out          signed OUT_W sample (from the generator)
//   int_b              one-clk interrupt B pulse (from the generator)
// Modports: master = register block / bench side, slave = tone generator.
interface audio_tone_gen_if #(
  parameter int OUT_W = 16
);
  logic                    ce;
  logic [11:0]             sq1_freq;
  logic [11:0]             sq2_freq;
  logic [7:0]              audio_ctl;
  logic [7:0]              volume;
  logic                    ctl_wr;
  logic signed [OUT_W-1:0] audio_out;
  logic                    int_b;

  modport master (
    output ce, sq1_freq, sq2_freq, audio_ctl, volume, ctl_wr,
    input  audio_out, int_b
  );

  modport slave (
    input  ce, sq1_freq, sq2_freq, audio_ctl, volume, ctl_wr,
    output audio_out, int_b
  );
endinterface

// File: rtl/audio_tone_gen.sv
// Gamate tone generator: two square channels, optional LFSR noise, interrupt B.
// Latency: audio_out registered one ce after the tick that changed a phase; int_b one clk after the tick.
// Backpressure: none; state advances only on ce, ctl_wr restarts the timebase in the same clk.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   bus (slave)   ce, sq1_freq, sq2_freq, audio_ctl, volume, ctl_wr in; audio_out, int_b out
// Build option: define AUDIO_NOISE_EN to give modes C/E the LFSR noise channel;
//   without it C plays square 2 and E plays square 1 + square 2.
module audio_tone_gen #(
  parameter int PRESCALE_DIV = 128,
  parameter int OUT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  audio_tone_gen_if.slave  bus
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int S  = OUT_W - 9;

  logic [PW-1:0]           r_pre;
  logic [11:0]             r_cnt1;
  logic [11:0]             r_cnt2;
  logic                    r_ph1;
  logic                    r_ph2;
  logic [6:0]              r_div;
  logic                    r_int_b;
  logic signed [OUT_W-1:0] r_out;

  logic                    w_tick;
  logic                    w_tgl2;
  logic [3:0]              w_mode;
  logic [6:0]              w_mask;
  logic                    w_div_hit;
  logic                    w_int_sup;
  logic signed [OUT_W-1:0] w_amp;
  logic signed [OUT_W-1:0] w_full;
  logic signed [OUT_W-1:0] w_s1;
  logic signed [OUT_W-1:0] w_s2;
  logic signed [OUT_W-1:0] w_mix;
  logic                    w_unused;

  assign w_mode   = bus.audio_ctl[3:0];
  assign w_unused = bus.audio_ctl[7];
  assign w_tick   = bus.ce && (r_pre == PW'(PRESCALE_DIV - 1));

  // Channel 2 toggle event; ctl_wr on the same clk cancels it.
  assign w_tgl2 = w_tick && !bus.ctl_wr && (bus.sq2_freq != 12'd0) && (r_cnt2 == 12'd0);

  // Interrupt B fires on the tick that completes 2^prescaler ticks.
  assign w_mask    = 7'((8'd1 << bus.audio_ctl[6:4]) - 8'd1);
  assign w_div_hit = &(r_div | ~w_mask);
  assign w_int_sup = (w_mode inside {4'h0, 4'h2, 4'h8, 4'hA, 4'hC, 4'hE});

  // Timebase, channel counters/phases and interrupt divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_ph1  <= 1'b0;
      r_ph2  <= 1'b0;
      r_div  <= '0;
    end else if (bus.ctl_wr) begin
      r_pre  <= '0;
      r_cnt1 <= '0;
      r_cnt2 <= '0;
      r_ph1  <= 1'b0;
      r_ph2  <= 1'b0;
      r_div  <= '0;
    end else if (bus.ce) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;

      // A zero period parks the channel low; a new period is picked up at the next reload.
      if (bus.sq1_freq == 12'd0) begin
        r_cnt1 <= '0;
        r_ph1  <= 1'b0;
      end else if (w_tick) begin
        if (r_cnt1 == 12'd0) begin
          r_cnt1 <= bus.sq1_freq;
          r_ph1  <= ~r_ph1;
        end else begin
          r_cnt1 <= r_cnt1 - 1'b1;
        end
      end

      if (bus.sq2_freq == 12'd0) begin
        r_cnt2 <= '0;
        r_ph2  <= 1'b0;
      end else if (w_tick) begin
        if (r_cnt2 == 12'd0) begin
          r_cnt2 <= bus.sq2_freq;
          r_ph2  <= ~r_ph2;
        end else begin
          r_cnt2 <= r_cnt2 - 1'b1;
        end
      end

      if (w_tick) begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // int_b is a single-clk pulse whatever ce does on the following clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_int_b <= 1'b0;
    end else begin
      r_int_b <= w_tick && !bus.ctl_wr && w_div_hit && !w_int_sup;
    end
  end

`ifdef AUDIO_NOISE_EN
  logic [14:0]             r_lfsr;
  logic signed [OUT_W-1:0] w_nz;

  // x^15 + x^14 + 1, clocked by channel 2 toggles only while a noise mode is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 15'h7FFF;
    end else if (w_tgl2 && ((w_mode == 4'hC) || (w_mode == 4'hE))) begin
      r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end
  end

  assign w_nz = r_lfsr[0] ? w_amp : -w_amp;
`endif

  always_comb begin
    w_amp  = OUT_W'(bus.volume[6:0]) << S;
    w_full = OUT_W'(7'd127) << S;
    w_s1   = r_ph1 ? w_amp : -w_amp;
    w_s2   = r_ph2 ? w_amp : -w_amp;
    w_mix  = '0;
    case (w_mode)
      4'h2, 4'hA: w_mix = w_s1;
      4'h4:       w_mix = w_s2;
      4'h6:       w_mix = w_s1 + w_s2;
`ifdef AUDIO_NOISE_EN
      4'hC:       w_mix = w_nz;
      4'hE:       w_mix = w_s1 + w_nz;
`else
      4'hC:       w_mix = w_s2;
      4'hE:       w_mix = w_s1 + w_s2;
`endif
      4'h1, 4'hD: w_mix = w_amp;
      4'h0:       w_mix = bus.volume[7] ? -w_full : '0;
      4'h8:       w_mix = bus.volume[7] ? w_full : '0;
      default:    w_mix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (bus.ce) begin
      r_out <= w_mix;
    end
  end

  assign bus.audio_out = r_out;
  assign bus.int_b     = r_int_b;

endmodule
